// File: rtl/cpu_pkg.sv
// Definitions shared by the control unit and the memory stage:
// bus width, memory FSM state encoding and operation encoding.
package cpu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } mem_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_e;

  // Both strobes high is a control-unit fault; the write wins and it gets flagged.
  function automatic mem_op_e pick_op(input logic rd, input logic wr);
    return (wr || !rd) ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/mem_subsystem_if.sv
// Control-unit <-> memory-stage signal bundle.
// master = control unit, slave = mem_subsystem.
interface mem_subsystem_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] bus_in;
  logic              mar_in;
  logic              mdr_in;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] mdr_data;
  logic [ADDR_W-1:0] mar_data;
  logic              mem_busy;
  logic              mem_done;
  logic              mem_err;

  modport master (
    output bus_in, mar_in, mdr_in, read, write,
    input  mdr_data, mar_data, mem_busy, mem_done, mem_err
  );

  modport slave (
    input  bus_in, mar_in, mdr_in, read, write,
    output mdr_data, mar_data, mem_busy, mem_done, mem_err
  );

endinterface

// File: rtl/sync_ram.sv
// Single-port synchronous RAM, read-before-write, contents never reset.
module sync_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_subsystem.sv
// Memory stage: MAR/MDR, wait-state down-counter and request FSM
// in front of a single-port synchronous RAM.
//
//   state | meaning
//   IDLE  | MAR/MDR loadable, waiting for read or write
//   BUSY  | counting wait states; access happens when counter hits 0
//   DONE  | one-cycle mem_done
//   HOLD  | request still high after completion, wait for it to drop
module mem_subsystem
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mem_subsystem_if.slave        mem
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  mem_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] ram_rdata;
  logic              err_q, err_d;
  logic              done_q;
  logic              req;
  logic              access;
  logic              ram_we;

  assign req    = mem.read | mem.write;
  assign access = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  // A reset landing on the access edge must still suppress the write.
  assign ram_we = access && (op_q == OP_WR) && reset_n;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem.mar_in) begin
          mar_d = mem.bus_in[ADDR_W-1:0];
        end
        if (req) begin
          op_d    = pick_op(mem.read, mem.write);
          err_d   = err_q | (mem.read & mem.write);
          cnt_d   = WAIT_LD;
          state_d = ST_BUSY;
        end else if (mem.mdr_in) begin
          mdr_d = mem.bus_in;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (op_q == OP_RD) begin
            mdr_d = ram_rdata;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = req ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (!req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RD;
      cnt_q   <= 4'd0;
      mar_q   <= '0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Address the RAM with next-MAR so rdata for the held MAR is already valid
  // on the access edge; MDR then captures it there and shows it during DONE.
  sync_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (mar_d),
    .wdata (mdr_q),
    .rdata (ram_rdata)
  );

  assign mem.mdr_data = mdr_q;
  assign mem.mar_data = mar_q;
  assign mem.mem_busy = (state_q != ST_IDLE);
  assign mem.mem_done = done_q;
  assign mem.mem_err  = err_q;

endmodule

// File: tb/tb_mem_subsystem.sv
// Directed bench for mem_subsystem: one instance with 2 wait states, one with 0.
module tb_mem_subsystem;
  import cpu_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2_n;
  logic rst0_n;

  mem_subsystem_if #(.ADDR_W(AW), .DATA_W(DW)) m2 ();
  mem_subsystem_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();

  mem_subsystem #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) u_dut2 (
    .clk     (clk),
    .reset_n (rst2_n),
    .mem     (m2.slave)
  );

  mem_subsystem #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u_dut0 (
    .clk     (clk),
    .reset_n (rst0_n),
    .mem     (m0.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until mem_done is seen; lat = cycles after the request was raised, -1 on timeout.
  task automatic wait_done(input bit use0, output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if ((use0 ? m0.mem_done : m2.mem_done) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic load2(input logic [AW-1:0] a, input logic [DW-1:0] d);
    m2.bus_in = DW'(a); m2.mar_in = 1'b1; tick(); m2.mar_in = 1'b0;
    m2.bus_in = d;      m2.mdr_in = 1'b1; tick(); m2.mdr_in = 1'b0;
  endtask

  task automatic test_reset();
    m2.bus_in = '0; m2.mar_in = 0; m2.mdr_in = 0; m2.read = 0; m2.write = 0;
    m0.bus_in = '0; m0.mar_in = 0; m0.mdr_in = 0; m0.read = 0; m0.write = 0;
    rst2_n = 1'b0; rst0_n = 1'b0;
    tick(); tick();
    n_cmp += 6;
    if (m2.mdr_data !== 32'h0) begin n_bad++; $display("FAIL reset_mdr got %h want 0", m2.mdr_data); end
    if (m2.mar_data !== 9'h0) begin n_bad++; $display("FAIL reset_mar got %h want 0", m2.mar_data); end
    if (m2.mem_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", m2.mem_busy); end
    if (m2.mem_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", m2.mem_done); end
    if (m2.mem_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", m2.mem_err); end
    if (m0.mem_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy0 got %b want 0", m0.mem_busy); end
    rst2_n = 1'b1; rst0_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int lat;
    m2.bus_in = 32'h0000_0040; m2.mar_in = 1'b1; tick(); m2.mar_in = 1'b0;
    n_cmp++;
    if (m2.mar_data !== 9'h040) begin n_bad++; $display("FAIL wr_mar got %h want 040", m2.mar_data); end
    m2.bus_in = 32'hDEAD_BEEF; m2.mdr_in = 1'b1; tick(); m2.mdr_in = 1'b0;
    n_cmp++;
    if (m2.mdr_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_mdr got %h want deadbeef", m2.mdr_data); end
    m2.write = 1'b1;
    wait_done(1'b0, lat);
    n_cmp += 2;
    if (lat !== 4) begin n_bad++; $display("FAIL wr_latency got %0d want 4", lat); end
    if (m2.mem_busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy_in_done got %b want 1", m2.mem_busy); end
    m2.write = 1'b0;
    tick();
    n_cmp += 2;
    if (m2.mem_done !== 1'b0) begin n_bad++; $display("FAIL wr_done_width got %b want 0", m2.mem_done); end
    if (m2.mem_busy !== 1'b0) begin n_bad++; $display("FAIL wr_back_idle got %b want 0", m2.mem_busy); end
    m2.bus_in = 32'h0; m2.mdr_in = 1'b1; tick(); m2.mdr_in = 1'b0;
    n_cmp++;
    if (m2.mdr_data !== 32'h0) begin n_bad++; $display("FAIL rd_mdr_clear got %h want 0", m2.mdr_data); end
    m2.read = 1'b1;
    wait_done(1'b0, lat);
    n_cmp += 3;
    if (lat !== 4) begin n_bad++; $display("FAIL rd_latency got %0d want 4", lat); end
    if (m2.mdr_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data got %h want deadbeef", m2.mdr_data); end
    if (m2.mem_err !== 1'b0) begin n_bad++; $display("FAIL rd_err got %b want 0", m2.mem_err); end
    m2.read = 1'b0;
    tick();
  endtask

  task automatic test_wait0();
    int lat;
    m0.bus_in = 32'h0000_01FF; m0.mar_in = 1'b1; tick(); m0.mar_in = 1'b0;
    m0.bus_in = 32'h1234_5678; m0.mdr_in = 1'b1; tick(); m0.mdr_in = 1'b0;
    m0.write = 1'b1;
    wait_done(1'b1, lat);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL w0_wr_latency got %0d want 2", lat); end
    m0.write = 1'b0;
    tick();
    m0.bus_in = 32'h0; m0.mdr_in = 1'b1; tick(); m0.mdr_in = 1'b0;
    m0.read = 1'b1;
    wait_done(1'b1, lat);
    n_cmp += 3;
    if (lat !== 2) begin n_bad++; $display("FAIL w0_rd_latency got %0d want 2", lat); end
    if (m0.mdr_data !== 32'h1234_5678) begin n_bad++; $display("FAIL w0_rd_data got %h want 12345678", m0.mdr_data); end
    if (m0.mar_data !== 9'h1FF) begin n_bad++; $display("FAIL w0_mar got %h want 1ff", m0.mar_data); end
    m0.read = 1'b0;
    tick();
  endtask

  task automatic test_held();
    int lat;
    int pulses;
    int not_busy;
    m2.read = 1'b1;
    wait_done(1'b0, lat);
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL held_latency got %0d want 4", lat); end
    pulses = 0; not_busy = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m2.mem_done === 1'b1) pulses++;
      if (m2.mem_busy !== 1'b1) not_busy++;
    end
    n_cmp += 2;
    if (pulses !== 0) begin n_bad++; $display("FAIL held_extra_done got %0d want 0", pulses); end
    if (not_busy !== 0) begin n_bad++; $display("FAIL held_hold_busy got %0d idle cycles want 0", not_busy); end
    m2.read = 1'b0;
    tick();
    n_cmp += 2;
    if (m2.mem_busy !== 1'b0) begin n_bad++; $display("FAIL held_release got %b want 0", m2.mem_busy); end
    if (m2.mem_done !== 1'b0) begin n_bad++; $display("FAIL held_release_done got %b want 0", m2.mem_done); end
  endtask

  task automatic test_conflict();
    int lat;
    load2(9'h005, 32'hA5A5_A5A5);
    m2.read = 1'b1; m2.write = 1'b1;
    wait_done(1'b0, lat);
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL err_latency got %0d want 4", lat); end
    m2.read = 1'b0; m2.write = 1'b0;
    tick();
    n_cmp++;
    if (m2.mem_err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", m2.mem_err); end
    load2(9'h005, 32'h0);
    m2.read = 1'b1;
    wait_done(1'b0, lat);
    n_cmp += 2;
    if (m2.mdr_data !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL err_ram5 got %h want a5a5a5a5", m2.mdr_data); end
    if (m2.mem_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", m2.mem_err); end
    m2.read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    int lat;
    int pulses;
    load2(9'h033, 32'h1111_1111);
    m2.write = 1'b1;
    wait_done(1'b0, lat);
    m2.write = 1'b0;
    tick();
    load2(9'h033, 32'h2222_2222);
    m2.write = 1'b1;
    tick();              // accepted, counter=2
    tick();              // counter=1
    rst2_n = 1'b0; m2.write = 1'b0;
    tick();
    n_cmp += 4;
    if (m2.mem_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", m2.mem_busy); end
    if (m2.mem_err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_err got %b want 0", m2.mem_err); end
    if (m2.mdr_data !== 32'h0) begin n_bad++; $display("FAIL rst_mid_mdr got %h want 0", m2.mdr_data); end
    if (m2.mar_data !== 9'h0) begin n_bad++; $display("FAIL rst_mid_mar got %h want 0", m2.mar_data); end
    rst2_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m2.mem_done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL rst_mid_done got %0d pulses want 0", pulses); end
    load2(9'h033, 32'h0);
    m2.read = 1'b1;
    wait_done(1'b0, lat);
    n_cmp++;
    if (m2.mdr_data !== 32'h1111_1111) begin n_bad++; $display("FAIL rst_mid_ram got %h want 11111111", m2.mdr_data); end
    m2.read = 1'b0;
    tick();
  endtask

  task automatic test_interference();
    int lat;
    load2(9'h010, 32'hCAFE_F00D);
    m2.write = 1'b1;
    tick();
    m2.bus_in = 32'h7; m2.mar_in = 1'b1; tick(); m2.mar_in = 1'b0;
    n_cmp++;
    if (m2.mar_data !== 9'h010) begin n_bad++; $display("FAIL busy_mar got %h want 010", m2.mar_data); end
    m2.bus_in = 32'h1; m2.mdr_in = 1'b1; tick(); m2.mdr_in = 1'b0;
    n_cmp++;
    if (m2.mdr_data !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL busy_mdr got %h want cafef00d", m2.mdr_data); end
    wait_done(1'b0, lat);
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL busy_done_at got %0d want 1", lat); end
    m2.write = 1'b0;
    tick();
    load2(9'h010, 32'h0);
    m2.read = 1'b1;
    wait_done(1'b0, lat);
    n_cmp++;
    if (m2.mdr_data !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL busy_ram10 got %h want cafef00d", m2.mdr_data); end
    m2.read = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait0();
    test_held();
    test_conflict();
    test_reset_mid_write();
    test_interference();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
